spi_byte_streamer: RTL and testbench

Upstream feeder for the OBI SPI peripheral. Accepts a byte stream with per-byte D/C and end-of-frame flags, buffers it in a small FIFO, and drives the SPI peripheral's register map as an OBI manager: DATA_TX write, CTRL start write, completion poll. Also generates the external CS and DC display lines that the SPI peripheral does not provide.

---
 rtl/spi_byte_streamer.sv | 219 +++++++++++++++++++++
 tb/tb_spi_byte_streamer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_streamer.sv
// rtl/spi_byte_streamer.sv - byte FIFO feeding an OBI SPI peripheral, with display CS/DC generation
//
// Buffers {last, dc, byte} entries and, for each one, writes DATA_TX, writes CTRL with start,
// polls CTRL.start then STATUS.busy, and pops the entry. cs_no frames bytes up to a "last" byte.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   in_valid_i/in_ready_o        byte stream handshake; in_data_i byte, in_dc_i D/C, in_last_i end of frame
//   req_o/we_o/be_o/addr_o/wdata_o  OBI manager request channel
//   gnt_i/rvalid_i/err_i/rdata_i    OBI grant and response channel
//   cs_no, dc_o                  display chip select (active low) and D/C line
//   busy_o                       sequencer active or FIFO holding bytes
//   err_o, clr_err_i             sticky bus error flag and its clear
module spi_byte_streamer #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [31:0] SPI_BASE_ADDR = 32'h0,
    parameter logic [7:0]  CLK_DIV       = 8'h01,
    parameter logic        CPOL          = 1'b0,
    parameter logic        CPHA          = 1'b0,
    parameter int          CS_SETUP      = 2,
    parameter int          CS_HOLD       = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_data_i,
    input  logic        in_dc_i,
    input  logic        in_last_i,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic        err_i,
    input  logic [31:0] rdata_i,
    output logic        cs_no,
    output logic        dc_o,
    output logic        busy_o,
    output logic        err_o,
    input  logic        clr_err_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

    typedef enum logic [3:0] {
        ST_INIT_DIV, ST_INIT_CTRL, ST_IDLE, ST_CS_SETUP, ST_WR_DATA,
        ST_WR_CTRL, ST_POLL_START, ST_POLL_BUSY, ST_CS_HOLD
    } state_t;

    // FIFO entry layout: [9] last, [8] dc, [7:0] byte
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic [9:0]    head;
    logic          push, pop, rsp, bus_next;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, pend_q, pend_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        cs_n_q, cs_n_d, dc_q, dc_d, err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        unused_rdata;

    assign unused_rdata = ^rdata_i[31:2];

    assign head = mem_q[rptr_q];
    // A response is only meaningful while our single transaction is outstanding.
    assign rsp  = pend_q && rvalid_i;
    // An error response counts as "not busy" so the sequence never stalls on a faulty target.
    assign pop  = rsp && (state_q == ST_POLL_BUSY) && (err_i || !rdata_i[0]);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign in_ready_o = (count_q != DEPTH_C) || pop;
    assign push = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {in_last_i, in_dc_i, in_data_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT_DIV;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cs_n_q  <= cs_n_d;
            dc_q    <= dc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cs_n_d   = cs_n_q;
        dc_d     = dc_q;
        err_d    = err_q;
        cnt_d    = cnt_q + 8'd1;
        bus_next = 1'b0;

        if (req_q && gnt_i) pend_d = 1'b1;
        if (rsp)            pend_d = 1'b0;

        if (clr_err_i)      err_d = 1'b0;
        if (rsp && err_i)   err_d = 1'b1;

        case (state_q)
            ST_INIT_DIV:   if (rsp) state_d = ST_INIT_CTRL;
            ST_INIT_CTRL:  if (rsp) state_d = ST_IDLE;
            ST_IDLE: begin
                if (count_q != '0) begin
                    if (cs_n_q) begin
                        state_d = ST_CS_SETUP;
                        cs_n_d  = 1'b0;
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            // Request goes out the cycle after leaving, giving CS_SETUP cycles after the CS edge.
            ST_CS_SETUP:   if (int'(cnt_q) + 1 >= CS_SETUP) state_d = ST_WR_DATA;
            ST_WR_DATA:    if (rsp) state_d = ST_WR_CTRL;
            ST_WR_CTRL:    if (rsp) state_d = ST_POLL_START;
            ST_POLL_START: if (rsp && (err_i || !rdata_i[1])) state_d = ST_POLL_BUSY;
            ST_POLL_BUSY:  if (pop) state_d = head[9] ? ST_CS_HOLD : ST_IDLE;
            // The completing response cycle plus entry cycle already account for two hold cycles.
            ST_CS_HOLD: begin
                if (int'(cnt_q) + 2 >= CS_HOLD) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end
            end
            default:       state_d = ST_INIT_DIV;
        endcase

        if (state_d != state_q) cnt_d = '0;
        if ((state_d == ST_WR_DATA) && (state_q != ST_WR_DATA)) dc_d = head[8];

        case (state_d)
            ST_INIT_DIV, ST_INIT_CTRL, ST_WR_DATA,
            ST_WR_CTRL, ST_POLL_START, ST_POLL_BUSY: bus_next = 1'b1;
            default:                                 bus_next = 1'b0;
        endcase

        // Request fields are computed from the next state so a new transaction can start
        // the cycle right after the previous response (two cycles per transaction).
        if (req_q) begin
            if (gnt_i) req_d = 1'b0;
        end else if (bus_next && !pend_d) begin
            req_d = 1'b1;
            case (state_d)
                ST_INIT_DIV: begin
                    we_d = 1'b1; addr_d = SPI_BASE_ADDR + 32'h00C; wdata_d = {24'h0, CLK_DIV};
                end
                ST_INIT_CTRL: begin
                    we_d = 1'b1; addr_d = SPI_BASE_ADDR; wdata_d = {28'h0, CPHA, CPOL, 2'b01};
                end
                ST_WR_DATA: begin
                    we_d = 1'b1; addr_d = SPI_BASE_ADDR + 32'h008; wdata_d = {24'h0, head[7:0]};
                end
                ST_WR_CTRL: begin
                    we_d = 1'b1; addr_d = SPI_BASE_ADDR; wdata_d = {28'h0, CPHA, CPOL, 2'b11};
                end
                ST_POLL_START: begin
                    we_d = 1'b0; addr_d = SPI_BASE_ADDR; wdata_d = '0;
                end
                default: begin
                    we_d = 1'b0; addr_d = SPI_BASE_ADDR + 32'h004; wdata_d = '0;
                end
            endcase
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign be_o    = 4'b0001;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign cs_no   = cs_n_q;
    assign dc_o    = dc_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_spi_byte_streamer.sv
// tb/tb_spi_byte_streamer.sv - randomized scoreboard bench for spi_byte_streamer
`timescale 1ns/1ps
module tb_spi_byte_streamer;
    localparam logic [31:0] A_CTRL = 32'h000;
    localparam logic [31:0] A_STAT = 32'h004;
    localparam logic [31:0] A_DATA = 32'h008;
    localparam logic [31:0] A_DIV  = 32'h00C;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic in_valid_i = 1'b0, in_dc_i = 1'b0, in_last_i = 1'b0;
    logic [7:0] in_data_i = 8'h0;
    logic in_ready_o;
    logic req_o, we_o;
    logic [3:0] be_o;
    logic [31:0] addr_o, wdata_o;
    logic gnt_i;
    logic rvalid_i = 1'b0, err_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic cs_no, dc_o, busy_o, err_o;
    logic clr_err_i = 1'b0;

    logic gnt_en = 1'b1;
    assign gnt_i = req_o & gnt_en;

    spi_byte_streamer dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_dc_i(in_dc_i), .in_last_i(in_last_i),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .err_i(err_i), .rdata_i(rdata_i),
        .cs_no(cs_no), .dc_o(dc_o), .busy_o(busy_o), .err_o(err_o), .clr_err_i(clr_err_i)
    );

    always #5 clk = ~clk;
    int cycle = 0;
    always @(posedge clk) cycle++;

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] wdata; } wr_t;
    typedef struct { logic dc; logic last; } byte_t;
    wr_t   exp_wr[$];
    byte_t exp_byte[$];

    // Reference model: every accepted byte produces a DATA_TX write then a CTRL start write.
    task automatic model_byte(input logic [7:0] b, input logic dc, input logic last);
        exp_wr.push_back('{A_DATA, {24'h0, b}});
        exp_wr.push_back('{A_CTRL, 32'h3});
        exp_byte.push_back('{dc, last});
    endtask

    task automatic model_init();
        exp_wr.delete();
        exp_byte.delete();
        exp_wr.push_back('{A_DIV, 32'h1});
        exp_wr.push_back('{A_CTRL, 32'h1});
    endtask

    // Target: optional grant stalls, response one cycle after grant, scripted poll results.
    logic tgt_pend = 1'b0, tgt_we = 1'b0;
    logic [31:0] tgt_addr = 32'h0;
    int start_left = 0, stat_left = 0;
    logic busy_hold = 1'b0, inject_err = 1'b0, stall_en = 1'b0;
    always @(negedge clk) begin
        rvalid_i = 1'b0;
        err_i    = 1'b0;
        rdata_i  = 32'h0;
        if (rst_i) begin
            tgt_pend = 1'b0;
        end else begin
            if (tgt_pend) begin
                rvalid_i = 1'b1;
                if (tgt_we) begin
                    if (tgt_addr == A_DATA && inject_err) begin
                        err_i = 1'b1;
                        inject_err = 1'b0;
                    end
                end else if (tgt_addr == A_CTRL) begin
                    rdata_i = {30'h0, (start_left > 0), 1'b1};
                    if (start_left > 0) start_left--;
                end else begin
                    rdata_i = {31'h0, (busy_hold || stat_left > 0)};
                    if (stat_left > 0 && !busy_hold) stat_left--;
                end
            end
            gnt_en   = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            tgt_pend = req_o && gnt_en;
            tgt_addr = addr_o;
            tgt_we   = we_o;
            if (tgt_pend && we_o && addr_o == A_CTRL) begin
                start_left = $urandom_range(0, 2);
                stat_left  = $urandom_range(0, 2);
            end
        end
    end

    // Monitor: pops the scoreboard on every granted request and tracks frame/CS timing.
    int phase = 0;              // 0 none, 3 data written, 1 polling CTRL, 2 polling STATUS
    logic cur_dc = 1'b0, prev_gnt = 1'b0, prev_stall = 1'b0, prev_cs = 1'b1;
    logic rd_we = 1'b0, want_rise = 1'b0, want_setup = 1'b0, st_we = 1'b0;
    logic [31:0] rd_addr = 32'h0, st_addr = 32'h0, st_wdata = 32'h0;
    int t_last = 0, t_fall = 0, frames_seen = 0;
    wr_t   mw;
    byte_t mb;
    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            phase = 0; prev_gnt = 1'b0; prev_stall = 1'b0; prev_cs = 1'b1;
            want_rise = 1'b0; want_setup = 1'b0;
        end else begin
            if (prev_cs && !cs_no) begin
                t_fall = cycle;
                want_setup = 1'b1;
            end
            if (!prev_cs && cs_no) begin
                check("cs_rise_expected", {31'h0, want_rise}, 32'h1);
                check("cs_hold_cycles", cycle - t_last, HOLD);
                want_rise = 1'b0;
                frames_seen++;
            end
            prev_cs = cs_no;
            if (want_setup && req_o) begin
                check("cs_setup_cycles", cycle - t_fall, SETUP);
                want_setup = 1'b0;
            end
            if (prev_gnt) check("req_drop_after_gnt", {31'h0, req_o}, 32'h0);
            if (prev_stall) begin
                check("req_held", {31'h0, req_o}, 32'h1);
                check("addr_held", addr_o, st_addr);
                check("wdata_held", wdata_o, st_wdata);
                check("we_held", {31'h0, we_o}, {31'h0, st_we});
            end
            if (rvalid_i) begin
                if (!rd_we && rd_addr == A_CTRL && phase == 1 && (err_i || !rdata_i[1])) begin
                    phase = 2;
                end else if (!rd_we && rd_addr == A_STAT && phase == 2 && (err_i || !rdata_i[0])) begin
                    phase = 0;
                    if (exp_byte.size() > 0) begin
                        mb = exp_byte.pop_front();
                        if (mb.last) begin
                            want_rise = 1'b1;
                            t_last = cycle;
                        end
                    end
                end
            end
            if (req_o && gnt_i) begin
                rd_we = we_o;
                rd_addr = addr_o;
                check("be_const", {28'h0, be_o}, 32'h1);
                if (phase != 0) check("dc_stable", {31'h0, dc_o}, {31'h0, cur_dc});
                if (we_o) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write_addr", addr_o, 32'hFFFF_FFFF);
                    end else begin
                        mw = exp_wr.pop_front();
                        check("write_addr", addr_o, mw.addr);
                        check("write_data", wdata_o, mw.wdata);
                    end
                    if (addr_o == A_DATA) begin
                        cur_dc = (exp_byte.size() > 0) ? exp_byte[0].dc : 1'b0;
                        check("dc_at_data", {31'h0, dc_o}, {31'h0, cur_dc});
                        check("cs_low_at_data", {31'h0, cs_no}, 32'h0);
                        phase = 3;
                    end
                    if (addr_o == A_CTRL && wdata_o[1]) phase = 1;
                end else begin
                    check("poll_addr", addr_o,
                          (phase == 1) ? A_CTRL : (phase == 2) ? A_STAT : 32'hFFFF_FFFF);
                end
            end
            prev_gnt   = req_o && gnt_i;
            prev_stall = req_o && !gnt_i;
            st_addr = addr_o; st_wdata = wdata_o; st_we = we_o;
        end
    end

    task automatic push(input logic [7:0] b, input logic dc, input logic last);
        int t;
        @(negedge clk); #2;
        in_valid_i = 1'b1; in_data_i = b; in_dc_i = dc; in_last_i = last;
        t = 0;
        while (!in_ready_o && t < 500) begin
            @(negedge clk); #2;
            t++;
        end
        check("push_accept", {31'h0, in_ready_o}, 32'h1);
        if (in_ready_o) begin
            model_byte(b, dc, last);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk); #2;
            t++;
        end while (!(!busy_o && cs_no && exp_wr.size() == 0) && t < 3000);
        check(name, {30'h0, busy_o, cs_no}, 32'h1);
        check({name, "_sb_empty"}, exp_wr.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_req", {31'h0, req_o}, 0);
        check("rst_we", {31'h0, we_o}, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_be", {28'h0, be_o}, 32'h1);
        check("rst_cs", {31'h0, cs_no}, 1);
        check("rst_dc", {31'h0, dc_o}, 0);
        check("rst_ready", {31'h0, in_ready_o}, 1);
        check("rst_busy", {31'h0, busy_o}, 1);
        check("rst_err", {31'h0, err_o}, 0);
    endtask

    initial begin
        int t, len;
        repeat (3) @(negedge clk);
        #2;
        check_reset_values();
        model_init();
        @(negedge clk); #2;
        rst_i = 1'b0;
        wait_idle("init_done");

        push(8'hA5, 1'b1, 1'b1);
        wait_idle("single_byte");
        check("frames_after_single", frames_seen, 1);

        push(8'h2A, 1'b0, 1'b0);
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b1);
        wait_idle("three_byte_frame");
        check("frames_after_three", frames_seen, 2);

        busy_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'(i), 1'b0);
        @(negedge clk); #2;
        check("fifo_full_ready_low", {31'h0, in_ready_o}, 0);
        fork
            begin
                repeat (100) @(posedge clk);
                busy_hold = 1'b0;
            end
        join_none
        push(8'h44, 1'b1, 1'b0);
        push(8'h45, 1'b0, 1'b1);
        wait_idle("backpressure");

        inject_err = 1'b1;
        push(8'h5C, 1'b1, 1'b1);
        wait_idle("err_byte");
        check("err_set", {31'h0, err_o}, 1);
        repeat (3) @(negedge clk);
        #2;
        check("err_sticky", {31'h0, err_o}, 1);
        clr_err_i = 1'b1;
        @(negedge clk); #2;
        clr_err_i = 1'b0;
        check("err_cleared", {31'h0, err_o}, 0);

        stall_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++)
                push(8'($urandom), 1'($urandom), (k == len - 1));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle("random_frames");
        check("random_bytes_done", exp_byte.size(), 0);
        stall_en = 1'b0;

        busy_hold = 1'b1;
        push(8'h77, 1'b0, 1'b1);
        t = 0;
        while (phase != 2 && t < 300) begin
            @(negedge clk); #2;
            t++;
        end
        check("reached_poll_busy", phase, 2);
        repeat (2) @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_cs", {31'h0, cs_no}, 1);
        check("midrst_req", {31'h0, req_o}, 0);
        check("midrst_ready", {31'h0, in_ready_o}, 1);
        check("midrst_busy", {31'h0, busy_o}, 1);
        busy_hold = 1'b0;
        model_init();
        repeat (2) @(negedge clk);
        #2;
        rst_i = 1'b0;
        wait_idle("reinit_done");
        check("flushed_bytes", exp_byte.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
